// File: rtl/das_pkg.sv
// Shared state encoding and default sizing for the DelayAndSum stream scheduler.
package das_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_ERR
    } das_state_e;

    localparam int DAS_NCH   = 4;
    localparam int DAS_LEN_W = 16;
    localparam int DAS_NFR_W = 8;
    localparam int DAS_TMO_W = 20;
    localparam int DAS_TOT_W = DAS_LEN_W + DAS_NFR_W;

endpackage

// File: rtl/das_sched_watchdog.sv
// Idle-cycle counter for the stream scheduler; timeout asserts once the counter saturates
// while the scheduler is active. Only built when DAS_SCHED_WATCHDOG_EN is defined.
module das_sched_watchdog #(
    parameter int TMO_W = 20
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic active_i,
    input  logic clear_i,
    output logic timeout_o
);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !active_i) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = active_i & (cnt_q == '1);

endmodule

// File: rtl/das_stream_scheduler.sv
// Lockstep per-beat release of NCH source streams into the DelayAndSum kernel, TLAST generation
// and output drain tracking. Define DAS_SCHED_WATCHDOG_EN to add the stall watchdog and ERR state.
module das_stream_scheduler
    import das_pkg::*;
#(
    parameter int NCH   = DAS_NCH,
    parameter int LEN_W = DAS_LEN_W,
    parameter int NFR_W = DAS_NFR_W,
    parameter int TMO_W = DAS_TMO_W
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic [LEN_W-1:0] cfg_frame_len,
    input  logic [NFR_W-1:0] cfg_num_frames,
    input  logic [NCH-1:0]   s_tvalid,
    output logic [NCH-1:0]   s_tready,
    output logic [NCH-1:0]   m_tvalid,
    input  logic [NCH-1:0]   m_tready,
    output logic             m_tlast,
    input  logic             o_tvalid,
    input  logic             o_tready,
    output logic             busy,
    output logic             done,
    output logic [NFR_W-1:0] frame_idx,
    output logic             stall_err
);

    localparam int TOT_W = LEN_W + NFR_W;

    das_state_e       state_q, state_d;
    logic [NCH-1:0]   taken_q, taken_d, fire;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d, frame_len_q, frame_len_d;
    logic [NFR_W-1:0] frame_idx_q, frame_idx_d, num_frames_q, num_frames_d;
    logic [TOT_W-1:0] total_q, total_d, out_cnt_q, out_cnt_d;
    logic             done_q, done_d;
    logic             gate, complete, last_beat, last_frame, obeat, start_ok;

    assign gate = (state_q == ST_RUN);

    // Purely combinational gating: a channel that already delivered this beat sees valid/ready low.
    for (genvar g = 0; g < NCH; g++) begin : g_lane
        assign fire[g]     = gate & ~taken_q[g] & s_tvalid[g] & m_tready[g];
        assign m_tvalid[g] = gate & ~taken_q[g] & s_tvalid[g];
        assign s_tready[g] = gate & ~taken_q[g] & m_tready[g];
    end

    assign complete   = gate & (&(taken_q | fire));
    assign last_beat  = (beat_cnt_q == frame_len_q - LEN_W'(1));
    assign last_frame = (frame_idx_q == num_frames_q - NFR_W'(1));
    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign obeat      = o_tvalid & o_tready & busy;
    assign start_ok   = cfg_start & (cfg_frame_len != '0) & (cfg_num_frames != '0);
    assign m_tlast    = gate & last_beat;
    assign done       = done_q;
    assign frame_idx  = frame_idx_q;

`ifdef DAS_SCHED_WATCHDOG_EN
    logic stall_err_q, stall_err_d, timeout, wd_clear;

    assign wd_clear = (|fire) | obeat | (state_d != state_q);

    das_sched_watchdog #(
        .TMO_W (TMO_W)
    ) u_wd (
        .clk_i     (ap_clk),
        .rst_ni    (ap_rst_n),
        .active_i  (busy),
        .clear_i   (wd_clear),
        .timeout_o (timeout)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stall_err_q <= 1'b0;
        end else begin
            stall_err_q <= stall_err_d;
        end
    end

    assign stall_err = stall_err_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TMO_W > 0);
    assign stall_err  = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        taken_d      = taken_q;
        beat_cnt_d   = beat_cnt_q;
        frame_idx_d  = frame_idx_q;
        frame_len_d  = frame_len_q;
        num_frames_d = num_frames_q;
        total_d      = total_q;
        out_cnt_d    = out_cnt_q;
        done_d       = 1'b0;
`ifdef DAS_SCHED_WATCHDOG_EN
        stall_err_d  = stall_err_q;
`endif
        if (obeat && (out_cnt_q != total_q)) begin
            out_cnt_d = out_cnt_q + TOT_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d      = ST_RUN;
                    frame_len_d  = cfg_frame_len;
                    num_frames_d = cfg_num_frames;
                    total_d      = TOT_W'(cfg_frame_len) * TOT_W'(cfg_num_frames);
                    taken_d      = '0;
                    beat_cnt_d   = '0;
                    frame_idx_d  = '0;
                    out_cnt_d    = '0;
`ifdef DAS_SCHED_WATCHDOG_EN
                    stall_err_d  = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                taken_d = taken_q | fire;
                if (complete) begin
                    taken_d = '0;
                    if (last_beat) begin
                        beat_cnt_d  = '0;
                        frame_idx_d = frame_idx_q + NFR_W'(1);
                        if (last_frame) state_d = ST_DRAIN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (out_cnt_q == total_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase
`ifdef DAS_SCHED_WATCHDOG_EN
        if (timeout) begin
            state_d     = ST_ERR;
            done_d      = 1'b0;
            stall_err_d = 1'b1;
        end
`endif
        // Abort outranks everything, including a same-cycle start or drain completion.
        if (cfg_abort) begin
            state_d     = ST_IDLE;
            taken_d     = '0;
            beat_cnt_d  = '0;
            frame_idx_d = '0;
            out_cnt_d   = '0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= ST_IDLE;
            taken_q      <= '0;
            beat_cnt_q   <= '0;
            frame_idx_q  <= '0;
            frame_len_q  <= '0;
            num_frames_q <= '0;
            total_q      <= '0;
            out_cnt_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            taken_q      <= taken_d;
            beat_cnt_q   <= beat_cnt_d;
            frame_idx_q  <= frame_idx_d;
            frame_len_q  <= frame_len_d;
            num_frames_q <= num_frames_d;
            total_q      <= total_d;
            out_cnt_q    <= out_cnt_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_das_stream_scheduler.sv
// Scoreboard bench for das_stream_scheduler: runs are queued at start, a negedge monitor checks
// every handshake, TLAST/frame index, lockstep and done against a beat-index reference model.
module tb_das_stream_scheduler;

    localparam int NCH   = 4;
    localparam int LEN_W = 16;
    localparam int NFR_W = 8;
    localparam int TMO_W = 4;

    localparam int SG_BUSY = 0;
    localparam int SG_DONE = 1;
    localparam int SG_SRDY = 2;
    localparam int SG_MVLD = 3;
    localparam int SG_LAST = 4;
    localparam int SG_FIDX = 5;
    localparam int SG_SERR = 6;
    localparam int SG_PEND = 7;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n = 1'b0;
    logic             cfg_start = 1'b0, cfg_abort = 1'b0;
    logic [LEN_W-1:0] cfg_frame_len = '0;
    logic [NFR_W-1:0] cfg_num_frames = '0;
    logic [NCH-1:0]   s_tvalid = '1, m_tready = '1;
    logic [NCH-1:0]   s_tready, m_tvalid;
    logic             m_tlast, busy, done, stall_err;
    logic             o_tvalid = 1'b0, o_tready = 1'b0;
    logic [NFR_W-1:0] frame_idx;

    das_stream_scheduler #(
        .NCH(NCH), .LEN_W(LEN_W), .NFR_W(NFR_W), .TMO_W(TMO_W)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_frame_len(cfg_frame_len), .cfg_num_frames(cfg_num_frames),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .o_tvalid(o_tvalid), .o_tready(o_tready),
        .busy(busy), .done(done), .frame_idx(frame_idx), .stall_err(stall_err)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct { int len; int nfr; } run_t;
    typedef struct { string name; int sig; logic [63:0] exp; } dchk_t;

    run_t  run_q[$];
    dchk_t dir_q[$];
    int    errors = 0, checks = 0;
    int    abort_ep = 0;
    bit    expect_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] sample(input int sig);
        case (sig)
            SG_BUSY: return 64'(busy);
            SG_DONE: return 64'(done);
            SG_SRDY: return 64'(s_tready);
            SG_MVLD: return 64'(m_tvalid);
            SG_LAST: return 64'(m_tlast);
            SG_FIDX: return 64'(frame_idx);
            SG_SERR: return 64'(stall_err);
            SG_PEND: return 64'(run_q.size());
            default: return 'x;
        endcase
    endfunction

    // Monitor: the only process that compares; stimulus hands it directed expectations via dir_q.
    int hs[NCH];
    int out_seen = 0;
    int seen_ep  = 0;

    initial begin
        forever begin
            @(negedge ap_clk);
            if (seen_ep != abort_ep) begin
                seen_ep = abort_ep;
                for (int i = 0; i < NCH; i++) hs[i] = 0;
                out_seen = 0;
            end
            while (dir_q.size() != 0) begin
                dchk_t d;
                d = dir_q.pop_front();
                chk(d.name, sample(d.sig), d.exp);
            end
            if (done) begin
                if (run_q.size() == 0) begin
                    chk("done_without_run", 64'(done), 64'(0));
                end else begin
                    int tot;
                    tot = run_q[0].len * run_q[0].nfr;
                    for (int i = 0; i < NCH; i++) chk("beats_at_done", 64'(hs[i]), 64'(tot));
                    chk("out_beats_before_done", 64'(out_seen >= tot), 64'(1));
                    void'(run_q.pop_front());
                    for (int i = 0; i < NCH; i++) hs[i] = 0;
                    out_seen = 0;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                chk("src_eq_sink_hs", 64'(s_tvalid[i] & s_tready[i]), 64'(m_tvalid[i] & m_tready[i]));
                chk("mvalid_needs_svalid", 64'(m_tvalid[i] & ~s_tvalid[i]), 64'(0));
                chk("sready_needs_mready", 64'(s_tready[i] & ~m_tready[i]), 64'(0));
                if (m_tvalid[i] && m_tready[i] && run_q.size() != 0) begin
                    int n, len, tot;
                    n   = hs[i];
                    len = run_q[0].len;
                    tot = len * run_q[0].nfr;
                    chk("beat_overrun", 64'(n < tot), 64'(1));
                    chk("tlast", 64'(m_tlast), 64'((n % len) == len - 1));
                    chk("frame_idx", 64'(frame_idx), 64'(n / len));
                    hs[i]++;
                end
            end
            begin
                int mn, mx;
                mn = hs[0];
                mx = hs[0];
                for (int i = 1; i < NCH; i++) begin
                    if (hs[i] < mn) mn = hs[i];
                    if (hs[i] > mx) mx = hs[i];
                end
                chk("lockstep", 64'(mx - mn <= 1), 64'(1));
            end
            if (run_q.size() == 0) begin
                chk("idle_mvalid", 64'(m_tvalid), 64'(0));
                chk("idle_sready", 64'(s_tready), 64'(0));
                chk("idle_busy", 64'(busy), 64'(0));
            end else if (!done && !expect_err) begin
                chk("busy_in_run", 64'(busy), 64'(1));
            end
            if (run_q.size() != 0 && o_tvalid && o_tready) out_seen++;
`ifndef DAS_SCHED_WATCHDOG_EN
            chk("stall_err_tied", 64'(stall_err), 64'(0));
`endif
        end
    end

    task automatic cyc();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic expect_sig(input string name, input int sig, input logic [63:0] v);
        dchk_t d;
        d.name = name;
        d.sig  = sig;
        d.exp  = v;
        dir_q.push_back(d);
    endtask

    task automatic all_on();
        s_tvalid = '1;
        m_tready = '1;
        o_tvalid = 1'b1;
        o_tready = 1'b1;
    endtask

    task automatic drive_rand(input int pv);
        for (int i = 0; i < NCH; i++) begin
            s_tvalid[i] = ($urandom_range(99) < pv);
            m_tready[i] = ($urandom_range(99) < pv);
        end
        o_tvalid = ($urandom_range(99) < pv);
        o_tready = ($urandom_range(99) < pv);
    endtask

    task automatic do_abort();
        cfg_abort = 1'b1;
        cyc();
        cfg_abort = 1'b0;
        run_q.delete();
        abort_ep++;
    endtask

    // The run is queued only after the start edge so that no IDLE-cycle output beat is counted.
    task automatic start_run(input int len, input int nfr);
        cfg_frame_len  = LEN_W'(len);
        cfg_num_frames = NFR_W'(nfr);
        cfg_start      = 1'b1;
        o_tvalid       = 1'b0;
        cyc();
        cfg_start = 1'b0;
        if (len != 0 && nfr != 0) begin
            run_t r;
            r.len = len;
            r.nfr = nfr;
            run_q.push_back(r);
        end
    endtask

    task automatic wait_done(input int pv, input int bound);
        int n = 0;
        while (run_q.size() != 0 && n < bound) begin
            drive_rand(pv);
            cyc();
            n++;
        end
        if (run_q.size() != 0) begin
            expect_sig("run_drained_in_time", SG_PEND, 0);
            cyc();
            do_abort();
        end
        all_on();
        o_tvalid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < NCH; i++) hs[i] = 0;
        all_on();
        repeat (3) cyc();
        ap_rst_n = 1'b1;
        expect_sig("rst_busy", SG_BUSY, 0);
        expect_sig("rst_done", SG_DONE, 0);
        expect_sig("rst_sready", SG_SRDY, 0);
        expect_sig("rst_mvalid", SG_MVLD, 0);
        expect_sig("rst_tlast", SG_LAST, 0);
        expect_sig("rst_frame_idx", SG_FIDX, 0);
        expect_sig("rst_stall_err", SG_SERR, 0);
        cyc();

        // 4x2 run, everything ready: one beat per cycle, done one cycle after the drain cycle.
        start_run(4, 2);
        all_on();
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c == 3) expect_sig("t1_tlast_beat3", SG_LAST, 1);
            if (c == 4) expect_sig("t1_tlast_beat4", SG_LAST, 0);
            if (c == 8) begin
                expect_sig("t1_drain_busy", SG_BUSY, 1);
                expect_sig("t1_drain_done", SG_DONE, 0);
            end
            if (c == 9) expect_sig("t1_done_pulse", SG_DONE, 1);
            if (c == 10) expect_sig("t1_done_cleared", SG_DONE, 0);
        end
        wait_done(100, 20);

        // Channel 2 withholds beat 1 for five cycles; the others hold after firing once.
        start_run(4, 2);
        all_on();
        cyc();
        s_tvalid[2] = 1'b0;
        cyc();
        for (int c = 0; c < 4; c++) begin
            expect_sig("t2_hold_mvalid", SG_MVLD, 0);
            expect_sig("t2_hold_sready", SG_SRDY, 4'b0100);
            expect_sig("t2_hold_frame", SG_FIDX, 0);
            cyc();
        end
        s_tvalid[2] = 1'b1;
        wait_done(100, 40);

        // Kernel output delayed: DRAIN holds busy until the eighth output beat.
        start_run(4, 2);
        s_tvalid = '1;
        m_tready = '1;
        o_tvalid = 1'b0;
        o_tready = 1'b1;
        repeat (30) cyc();
        expect_sig("t3_drain_busy", SG_BUSY, 1);
        expect_sig("t3_drain_no_done", SG_DONE, 0);
        for (int k = 0; k < 8; k++) begin
            o_tvalid = 1'b1;
            cyc();
            o_tvalid = 1'b0;
            cyc();
            if (k == 6) begin
                expect_sig("t3_seven_no_done", SG_DONE, 0);
                expect_sig("t3_seven_busy", SG_BUSY, 1);
            end
            if (k == 7) expect_sig("t3_done_after_eight", SG_DONE, 1);
        end
        wait_done(100, 10);

        // Abort at beat 3 of frame 0, then abort+start together from IDLE, then a clean restart.
        start_run(4, 2);
        all_on();
        repeat (3) cyc();
        do_abort();
        expect_sig("abort_busy", SG_BUSY, 0);
        expect_sig("abort_mvalid", SG_MVLD, 0);
        expect_sig("abort_sready", SG_SRDY, 0);
        expect_sig("abort_frame_idx", SG_FIDX, 0);
        expect_sig("abort_tlast", SG_LAST, 0);
        repeat (3) begin
            cyc();
            expect_sig("abort_no_done", SG_DONE, 0);
        end
        cfg_frame_len  = 4;
        cfg_num_frames = 2;
        cfg_start      = 1'b1;
        cfg_abort      = 1'b1;
        cyc();
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        expect_sig("abort_beats_start", SG_BUSY, 0);
        cyc();
        start_run(3, 2);
        wait_done(75, 1000);

        // Zero-sized configurations are ignored.
        all_on();
        o_tvalid = 1'b0;
        start_run(0, 2);
        expect_sig("len0_busy", SG_BUSY, 0);
        expect_sig("len0_sready", SG_SRDY, 0);
        cyc();
        start_run(3, 0);
        expect_sig("nfr0_busy", SG_BUSY, 0);
        cyc();

        // Start while busy must not disturb the run in flight.
        start_run(3, 3);
        all_on();
        cyc();
        cfg_frame_len  = 5;
        cfg_num_frames = 1;
        cfg_start      = 1'b1;
        cyc();
        cfg_start = 1'b0;
        wait_done(75, 1000);

        // Randomized runs, including single-beat frames.
        start_run(1, 3);
        wait_done(75, 1000);
        for (int r = 0; r < 12; r++) begin
            start_run(int'($urandom_range(1, 6)), int'($urandom_range(1, 3)));
            wait_done(70, 2000);
            repeat (int'($urandom_range(0, 2))) cyc();
        end

`ifdef DAS_SCHED_WATCHDOG_EN
        // Kernel never ready: the watchdog trips, ERR closes the gate until abort.
        expect_err = 1'b1;
        s_tvalid   = '1;
        m_tready   = '0;
        o_tvalid   = 1'b0;
        start_run(4, 1);
        repeat (20) cyc();
        expect_sig("wd_stall_err", SG_SERR, 1);
        expect_sig("wd_err_busy", SG_BUSY, 0);
        expect_sig("wd_err_mvalid", SG_MVLD, 0);
        cyc();
        do_abort();
        expect_err = 1'b0;
        expect_sig("wd_abort_busy", SG_BUSY, 0);
        expect_sig("wd_sticky", SG_SERR, 1);
        cyc();
        m_tready = '1;
        start_run(2, 1);
        expect_sig("wd_clear_on_start", SG_SERR, 0);
        wait_done(100, 40);
`endif

        repeat (3) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
